// File: rtl/phase_ctrl_pkg.sv
// Shared definitions for the phase inverter sequencer family.
// State encodings and default widths used by the rail sequencers.
package phase_ctrl_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    localparam int WIDTH_DEF = 10;
    localparam int DT_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/dead_time_counter.sv
// Load/decrement down-counter with zero flag for dead-time sequencing.
// Ports: clk, rst (sync, active-high), load/load_val, dec, zero.
module dead_time_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            // Saturate at zero so a stray dec can never wrap the counter.
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/phase_inverter_sequencer.sv
// Sequences a complementary rail pair: plus first, minus after a dead time.
// Ports: wb_clk_i/wb_rst_i, enable, dead_cycles, in_valid/in_data/in_ready,
//        out_plus/out_minus, plus_strobe/minus_strobe, busy, sample_count.
module phase_inverter_sequencer
    import phase_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DT_W  = DT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
`ifdef USE_POWER_PINS
    inout  wire              vdd,
    inout  wire              vss,
`endif
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable,
    input  logic [DT_W-1:0]  dead_cycles,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_plus,
    output logic [WIDTH-1:0] out_minus,
    output logic             plus_strobe,
    output logic             minus_strobe,
    output logic             busy,
    output logic [CNT_W-1:0] sample_count
);

    logic [0:0]       state_q;
    logic [WIDTH-1:0] data_q;
    logic             dt_zero;
    logic             accept;
    logic             finish;
    logic             dt_dec;

    assign in_ready = (state_q == ST_IDLE) && enable && !wb_rst_i;
    assign accept   = in_ready && in_valid;
    assign finish   = (state_q == ST_DEAD) && dt_zero;
    assign dt_dec   = (state_q == ST_DEAD) && !dt_zero;
    assign busy     = (state_q == ST_DEAD);

    // The dead count is captured at accept; later dead_cycles edits are
    // invisible until the next sample.
    dead_time_counter #(
        .W(DT_W)
    ) u_dt (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (accept),
        .dec      (dt_dec),
        .load_val (dead_cycles),
        .zero     (dt_zero)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            out_plus     <= '0;
            out_minus    <= '0;
            plus_strobe  <= 1'b0;
            minus_strobe <= 1'b0;
            sample_count <= '0;
        end else begin
            plus_strobe  <= accept;
            minus_strobe <= finish;
            // accept only happens in IDLE and finish only in DEAD, so the
            // two rails can never be written on the same edge.
            if (accept) begin
                state_q  <= ST_DEAD;
                data_q   <= in_data;
                out_plus <= in_data;
            end else if (finish) begin
                state_q      <= ST_IDLE;
                out_minus    <= ~data_q;
                sample_count <= sample_count + CNT_W'(1);
            end
        end
    end

endmodule
